// File: rtl/comparator_max_scheduler.sv
// comparator_max_scheduler
//   Collects COUNT samples per frame over a valid/ready handshake. It keeps a
//   running maximum with one shared greater-than comparator and reports the
//   peak value and its 0-based index once per frame.
//
//   Optional build macro: COMPARATOR_MAX_SCHEDULER_MIN_EN. When it is defined,
//   a second comparator and the o_min/o_min_idx ports track the running minimum.
//
// Ports
//   i_clk      in   1      clock, rising edge
//   i_rst_n    in   1      asynchronous active-low reset
//   i_start    in   1      start a new frame (honoured in IDLE/DONE only)
//   i_valid    in   1      i_data valid
//   i_data     in   WIDTH  sample
//   o_ready    out  1      sample accepted this cycle if i_valid
//   o_busy     out  1      frame in progress
//   o_done     out  1      one-cycle pulse, frame result valid
//   o_max      out  WIDTH  largest sample of last completed frame
//   o_max_idx  out  IDX_W  index of that sample within the frame
//   o_min      out  WIDTH  smallest sample of last frame (MIN_EN only)
//   o_min_idx  out  IDX_W  index of that sample (MIN_EN only)
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | waiting for i_start
// S_RUN  | accepting samples, one comparison per accept
// S_DONE | single cycle, result presented with o_done

module comparator_greater_than #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_gt
);
    assign o_gt = (i_A > i_B);
endmodule

module comparator_max_scheduler #(
    parameter int WIDTH = 4,
    parameter int COUNT = 8,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_max,
    output logic [IDX_W-1:0] o_max_idx
`ifdef COMPARATOR_MAX_SCHEDULER_MIN_EN
    ,
    output logic [WIDTH-1:0] o_min,
    output logic [IDX_W-1:0] o_min_idx
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] run_max, run_max_nxt;
    logic [IDX_W-1:0] run_max_idx, run_max_idx_nxt;
    logic             max_gt;
    logic             res_load;

    comparator_greater_than #(.WIDTH(WIDTH)) u_cmp_max (
        .i_A  (i_data),
        .i_B  (run_max),
        .o_gt (max_gt)
    );

`ifdef COMPARATOR_MAX_SCHEDULER_MIN_EN
    logic [WIDTH-1:0] run_min, run_min_nxt;
    logic [IDX_W-1:0] run_min_idx, run_min_idx_nxt;
    logic             min_gt;

    comparator_greater_than #(.WIDTH(WIDTH)) u_cmp_min (
        .i_A  (run_min),
        .i_B  (i_data),
        .o_gt (min_gt)
    );
`endif

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        run_max_nxt     = run_max;
        run_max_idx_nxt = run_max_idx;
`ifdef COMPARATOR_MAX_SCHEDULER_MIN_EN
        run_min_nxt     = run_min;
        run_min_idx_nxt = run_min_idx;
`endif
        res_load        = 1'b0;
        o_ready         = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt       = S_RUN;
                    cnt_nxt         = '0;
                    run_max_nxt     = '0;
                    run_max_idx_nxt = '0;
`ifdef COMPARATOR_MAX_SCHEDULER_MIN_EN
                    run_min_nxt     = '0;
                    run_min_idx_nxt = '0;
`endif
                end
            end
            S_RUN: begin
                o_ready = 1'b1;
                o_busy  = 1'b1;
                if (i_valid) begin
                    // First sample of the frame seeds the running regs; the
                    // comparator result is ignored on that cycle.
                    if ((cnt == '0) || max_gt) begin
                        run_max_nxt     = i_data;
                        run_max_idx_nxt = cnt;
                    end
`ifdef COMPARATOR_MAX_SCHEDULER_MIN_EN
                    if ((cnt == '0) || min_gt) begin
                        run_min_nxt     = i_data;
                        run_min_idx_nxt = cnt;
                    end
`endif
                    if (cnt == LAST) begin
                        state_nxt = S_DONE;
                        res_load  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    state_nxt       = S_RUN;
                    cnt_nxt         = '0;
                    run_max_nxt     = '0;
                    run_max_idx_nxt = '0;
`ifdef COMPARATOR_MAX_SCHEDULER_MIN_EN
                    run_min_nxt     = '0;
                    run_min_idx_nxt = '0;
`endif
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results load on the last accept edge, so they are already stable while
    // o_done is high and stay untouched by the next frame until its own end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            run_max     <= '0;
            run_max_idx <= '0;
            o_max       <= '0;
            o_max_idx   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            run_max     <= run_max_nxt;
            run_max_idx <= run_max_idx_nxt;
            if (res_load) begin
                o_max     <= run_max_nxt;
                o_max_idx <= run_max_idx_nxt;
            end
        end
    end

`ifdef COMPARATOR_MAX_SCHEDULER_MIN_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_min     <= '0;
            run_min_idx <= '0;
            o_min       <= '0;
            o_min_idx   <= '0;
        end else begin
            run_min     <= run_min_nxt;
            run_min_idx <= run_min_idx_nxt;
            if (res_load) begin
                o_min     <= run_min_nxt;
                o_min_idx <= run_min_idx_nxt;
            end
        end
    end
`endif

endmodule
